// File: rtl/dac_waveform_player.sv
// dac_waveform_player: AXI-Stream loaded waveform RAM replayed to a DAC stream
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_mode/cfg_repeat      replay mode and pass count, latched at PLAY entry
//   cfg_load/arm/abort       single-cycle control pulses
//   trigger_in, select_in    replay start (level) and channel enable
//   s_axis_*                 waveform load stream (ready only in LOAD)
//   m_axis_*                 DAC beat stream, valid from the first clock after reset
//   state, wave_len          FSM state and stored waveform length
//   pass_cnt, done           completed passes and end-of-playback pulse
//   load_ovf, arm_err        sticky load-overflow and arm-with-empty-RAM flags
module dac_waveform_player #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic              cfg_load,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic              trigger_in,
  input  logic              select_in,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   wave_len,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              done,
  output logic              load_ovf,
  output logic              arm_err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, ARMED = 3'd2, PLAY = 3'd3} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wave_len_q, wave_len_d;
  logic [CNT_W-1:0] pass_q, pass_d, ipass_q, ipass_d, tgt_q, tgt_d;
  logic cont_q, cont_d, iss_q, iss_d, load_ovf_q, load_ovf_d, arm_err_q, arm_err_d, tvalid_q;
  logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_fin_q, s1_fin_d;
  logic o_last_q, o_last_d, o_fin_q, o_fin_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q, data_q, data_d;
  logic adv, acc_s, issue, i_last, i_fin, acc_last;
  // Two-stage read pipeline (RAM register, output register) that advances as a
  // whole on every accepted output beat, so the RAM stage acts as the prefetch.
  always_comb begin
    adv = tvalid_q & m_axis_tready;
    acc_s = (state_q == LOAD) & s_axis_tvalid;
    issue = (state_q == PLAY) & iss_q & adv & ~cfg_abort;
    i_last = {1'b0, rd_ptr_q} == wave_len_q - 1'b1;
    i_fin = i_last & ~cont_q & (ipass_q + 1'b1 == tgt_q);
    acc_last = adv & o_last_q & (state_q == PLAY) & ~cfg_abort;
    done = acc_last & o_fin_q;
    s1_vld_d = cfg_abort ? 1'b0 : adv ? issue : s1_vld_q;
    s1_last_d = adv ? i_last : s1_last_q;
    s1_fin_d = adv ? i_fin : s1_fin_q;
    data_d = adv ? ((s1_vld_q & ~cfg_abort) ? ram_q : '0) : data_q;
    o_last_d = ~cfg_abort & (adv ? s1_vld_q & s1_last_q : o_last_q);
    o_fin_d = ~cfg_abort & (adv ? s1_vld_q & s1_fin_q : o_fin_q);
  end
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wave_len_d = wave_len_q;
    pass_d = pass_q;
    ipass_d = ipass_q;
    tgt_d = tgt_q;
    cont_d = cont_q;
    iss_d = iss_q;
    load_ovf_d = load_ovf_q;
    arm_err_d = arm_err_q;
    if (cfg_abort) begin
      state_d = IDLE;
      iss_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_load) begin
            state_d = LOAD;
            wr_ptr_d = '0;
            load_ovf_d = 1'b0;
          end else if (cfg_arm) begin
            state_d = (wave_len_q != '0) ? ARMED : IDLE;
            arm_err_d = wave_len_q == '0;
          end
        end
        LOAD: begin
          if (acc_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast || &wr_ptr_q) begin
              state_d = IDLE;
              wave_len_d = {1'b0, wr_ptr_q} + 1'b1;
              load_ovf_d = ~s_axis_tlast;
            end
          end
        end
        ARMED: begin
          if (trigger_in & select_in) begin
            state_d = PLAY;
            rd_ptr_d = '0;
            pass_d = '0;
            ipass_d = '0;
            iss_d = 1'b1;
            cont_d = cfg_mode == 2'd2;
            tgt_d = (cfg_mode == 2'd1 && cfg_repeat != '0) ? cfg_repeat : CNT_W'(1);
          end
        end
        PLAY: begin
          // Issue side counts passes to know where to stop reading; the output
          // side counts accepted passes and ends playback on the final beat.
          if (issue) begin
            rd_ptr_d = i_last ? '0 : rd_ptr_q + 1'b1;
            ipass_d = i_last ? ipass_q + 1'b1 : ipass_q;
            iss_d = ~i_fin;
          end
          if (acc_last) begin
            pass_d = pass_q + 1'b1;
            state_d = o_fin_q ? ARMED : PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (acc_s) mem[wr_ptr_q] <= s_axis_tdata;
    if (issue) ram_q <= mem[rd_ptr_q];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wave_len_q <= '0;
      pass_q <= '0;
      ipass_q <= '0;
      tgt_q <= '0;
      cont_q <= 1'b0;
      iss_q <= 1'b0;
      load_ovf_q <= 1'b0;
      arm_err_q <= 1'b0;
      tvalid_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_fin_q <= 1'b0;
      o_last_q <= 1'b0;
      o_fin_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wave_len_q <= wave_len_d;
      pass_q <= pass_d;
      ipass_q <= ipass_d;
      tgt_q <= tgt_d;
      cont_q <= cont_d;
      iss_q <= iss_d;
      load_ovf_q <= load_ovf_d;
      arm_err_q <= arm_err_d;
      tvalid_q <= 1'b1;
      s1_vld_q <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_fin_q <= s1_fin_d;
      o_last_q <= o_last_d;
      o_fin_q <= o_fin_d;
      data_q <= data_d;
    end
  end
  assign state = state_q;
  assign s_axis_tready = state_q == LOAD;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata = data_q;
  assign wave_len = wave_len_q;
  assign pass_cnt = pass_q;
  assign load_ovf = load_ovf_q;
  assign arm_err = arm_err_q;
endmodule

// File: tb/tb_dac_waveform_player.sv
// tb_dac_waveform_player: directed and randomized checks of load, replay modes, abort and reset
module tb_dac_waveform_player;
  localparam int DW = 256, AW = 12, CW = 16, DEPTH = 1 << AW;
  logic clk = 0, rst = 0;
  logic [1:0] cfg_mode = 0;
  logic [CW-1:0] cfg_repeat = 0;
  logic cfg_load = 0, cfg_arm = 0, cfg_abort = 0, trigger_in = 0, select_in = 0;
  logic [DW-1:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready = 1;
  logic [2:0] state;
  logic [AW:0] wave_len;
  logic [CW-1:0] pass_cnt;
  logic done, load_ovf, arm_err;
  int checks = 0, errors = 0;
  logic [DW-1:0] wv [DEPTH];
  int wlen = 0;

  always #5 clk = ~clk;

  dac_waveform_player #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_repeat(cfg_repeat),
    .cfg_load(cfg_load), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .trigger_in(trigger_in), .select_in(select_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .state(state), .wave_len(wave_len), .pass_cnt(pass_cnt),
    .done(done), .load_ovf(load_ovf), .arm_err(arm_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r | 1;
  endfunction

  task automatic load(input int n, input bit tl, output int acc);
    logic [DW-1:0] d;
    cfg_load = 1;
    cyc();
    cfg_load = 0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      d = rnd();
      s_axis_tdata = d;
      s_axis_tvalid = 1;
      s_axis_tlast = tl && (i == n - 1);
      @(negedge clk);
      if (s_axis_tready) begin
        wv[acc] = d;
        acc++;
      end
      cyc();
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
  endtask

  task automatic arm();
    cfg_arm = 1;
    cyc();
    cfg_arm = 0;
  endtask

  // Expected stream: trigger seen at edge T, beat j of the playback sits on
  // tdata after edge T+2+j, done with the final beat, ARMED after it is taken.
  task automatic play(input logic [1:0] mode, input logic [CW-1:0] rep);
    int passes, total;
    logic [DW-1:0] e;
    passes = (mode == 2'd1) ? ((rep == 0) ? 1 : int'(rep)) : 1;
    total = passes * wlen;
    cfg_mode = mode;
    cfg_repeat = rep;
    select_in = 1;
    trigger_in = 1;
    m_axis_tready = 1;
    cyc();
    trigger_in = 0;
    for (int k = 0; k <= total + 3; k++) begin
      if (k == 1) begin
        cfg_mode = 2'd2;
        cfg_repeat = 7;
      end
      @(negedge clk);
      e = '0;
      if (k >= 2 && k - 2 < total) e = wv[(k - 2) % wlen];
      chk("play_data", m_axis_tdata, e);
      chk("play_done", done, k - 2 == total - 1);
      chk("play_state", state, (k < total + 2) ? 3 : 2);
      cyc();
    end
    chk("pass_cnt", pass_cnt, passes);
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, idx;
    bit started, prev_stall;
    logic [DW-1:0] prevd, h;
    #12;
    chk("rst_state", state, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_wave_len", wave_len, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("tvalid_before", m_axis_tvalid, 0);
    @(negedge clk);
    chk("tvalid_after", m_axis_tvalid, 1);
    chk("idle_tdata", m_axis_tdata, 0);
    cyc();

    arm();
    @(negedge clk);
    chk("arm_empty_state", state, 0);
    chk("arm_err_set", arm_err, 1);
    cyc();

    load(4, 1, acc);
    wlen = acc;
    for (int i = 0; i < 4; i++) wv[i] = DW'(i + 1);
    cfg_load = 1;
    cyc();
    cfg_load = 0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = wv[i];
      s_axis_tvalid = 1;
      s_axis_tlast = i == 3;
      @(negedge clk);
      chk("load_ready", s_axis_tready, 1);
      cyc();
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    @(negedge clk);
    chk("load_wave_len", wave_len, 4);
    chk("load_idle", state, 0);
    chk("load_no_ovf", load_ovf, 0);
    chk("load_ready_off", s_axis_tready, 0);
    cyc();
    arm();
    @(negedge clk);
    chk("arm_state", state, 2);
    chk("arm_err_clr", arm_err, 0);
    cyc();

    play(2'd0, 0);
    play(2'd1, 3);
    play(2'd3, 0);
    play(2'd1, 0);

    cfg_mode = 2'd2;
    select_in = 1;
    trigger_in = 1;
    idx = 0;
    started = 0;
    prev_stall = 0;
    prevd = '0;
    for (int c = 0; c < 200; c++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) chk("stall_stable", m_axis_tdata, prevd);
      if (m_axis_tready && (started || m_axis_tdata != 0)) begin
        started = 1;
        chk("cont_beat", m_axis_tdata, wv[idx % wlen]);
        idx++;
      end
      prev_stall = !m_axis_tready;
      prevd = m_axis_tdata;
      cyc();
      trigger_in = 0;
    end
    chk("cont_progress", idx > 40, 1);
    m_axis_tready = 0;
    @(negedge clk);
    h = m_axis_tdata;
    chk("held_nonzero", h != 0, 1);
    cyc();
    cfg_abort = 1;
    @(negedge clk);
    chk("abort_hold", m_axis_tdata, h);
    cyc();
    cfg_abort = 0;
    @(negedge clk);
    chk("abort_idle", state, 0);
    chk("abort_hold2", m_axis_tdata, h);
    cyc();
    m_axis_tready = 1;
    @(negedge clk);
    chk("abort_present", m_axis_tdata, h);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("abort_zero", m_axis_tdata, 0);
    end
    cyc();

    arm();
    select_in = 0;
    trigger_in = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("nosel_state", state, 2);
      chk("nosel_zero", m_axis_tdata, 0);
    end
    cyc();
    trigger_in = 0;
    cfg_load = 1;
    cyc();
    cfg_load = 0;
    @(negedge clk);
    chk("load_in_armed", state, 2);
    cyc();
    cfg_abort = 1;
    cyc();
    cfg_abort = 0;

    cfg_load = 1;
    cfg_arm = 1;
    cyc();
    cfg_load = 0;
    cfg_arm = 0;
    @(negedge clk);
    chk("load_over_arm", state, 1);
    cyc();
    s_axis_tvalid = 1;
    s_axis_tdata = rnd();
    cyc();
    cfg_abort = 1;
    cyc();
    cfg_abort = 0;
    s_axis_tvalid = 0;
    @(negedge clk);
    chk("abort_load_state", state, 0);
    chk("abort_load_ready", s_axis_tready, 0);
    chk("abort_load_len", wave_len, 4);
    cyc();

    load(DEPTH + 3, 0, acc);
    wlen = DEPTH;
    chk("ovf_accepted", acc, DEPTH);
    @(negedge clk);
    chk("ovf_ready", s_axis_tready, 0);
    chk("ovf_flag", load_ovf, 1);
    chk("ovf_len", wave_len, DEPTH);
    chk("ovf_idle", state, 0);
    cyc();

    arm();
    cfg_mode = 2'd2;
    select_in = 1;
    trigger_in = 1;
    m_axis_tready = 1;
    cyc();
    trigger_in = 0;
    for (int i = 0; i < 6; i++) cyc();
    @(negedge clk);
    chk("mid_play_beat", m_axis_tdata, wv[4]);
    cyc();
    m_axis_tready = 0;
    cyc();
    #2;
    rst = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_s_tready", s_axis_tready, 0);
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_tdata", m_axis_tdata, 0);
    chk("arst_wave_len", wave_len, 0);
    chk("arst_pass_cnt", pass_cnt, 0);
    chk("arst_done", done, 0);
    chk("arst_load_ovf", load_ovf, 0);
    chk("arst_arm_err", arm_err, 0);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("rel_tvalid0", m_axis_tvalid, 0);
    @(negedge clk);
    chk("rel_tvalid1", m_axis_tvalid, 1);
    chk("rel_tdata", m_axis_tdata, 0);
    chk("rel_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
